uart_rx_8n1: RTL and testbench

UART receiver for 8 data bits, no parity, 1 stop bit (8N1). It is the downstream counterpart of the team's 8N1 transmitter and consumes the serial line that the transmitter drives. It oversamples the asynchronous serial input on the system clock and samples each bit at mid-bit. It presents each received byte with a one-cycle valid strobe, and flags framing errors.

---
 rtl/uart_rx_8n1_pkg.sv | 14 +
 rtl/uart_rx_8n1_if.sv | 16 +
 rtl/uart_rx_8n1_sync_2ff.sv | 27 ++
 rtl/uart_rx_8n1.sv | 108 ++++++++++
 tb/tb_uart_rx_8n1.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_8n1_pkg.sv
// uart_rx_8n1_pkg: shared constants for the 8N1 receiver (FSM encodings, default bit period)
package uart_rx_8n1_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 1250;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_DATA  = 3'd2;
    localparam state_t ST_STOP  = 3'd3;
    localparam state_t ST_BREAK = 3'd4;

endpackage

// File: rtl/uart_rx_8n1_if.sv
// uart_rx_8n1_if: serial line plus received-byte signals
//   uart_rx   serial line into the receiver
//   rx_data   last correctly framed byte
//   rx_valid  one-cycle strobe, rx_data updated in the same cycle
//   frame_err one-cycle strobe on a low stop bit
//   rx_busy   receiver is not idle
interface uart_rx_8n1_if;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    modport master (input uart_rx, output rx_data, rx_valid, frame_err, rx_busy);
    modport slave  (output uart_rx, input rx_data, rx_valid, frame_err, rx_busy);
endinterface

// File: rtl/uart_rx_8n1_sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input
//   clk, rst_n  clock and asynchronous active-low reset
//   d_i         asynchronous input
//   q_o         synchronized output, RESET_VAL while in reset
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver, mid-bit sampling, valid and framing-error strobes
//   clk, rst_n  system clock and asynchronous active-low reset
//   bus         uart_rx_8n1_if.master: uart_rx in; rx_data, rx_valid, frame_err, rx_busy out
module uart_rx_8n1
    import uart_rx_8n1_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_8n1_if.master  bus
);
    if (CLKS_PER_BIT < 4) begin : g_param_check
        $error("uart_rx_8n1: CLKS_PER_BIT must be at least 4");
    end

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic          rx_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.uart_rx),
        .q_o   (rx_s)
    );

    // START waits half a bit to land on the centre of the start bit; every
    // later sample is a full bit period after the previous one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = ST_START;
            end
            ST_START: if (cnt_q == HALF_M1) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (cnt_q == FULL_M1) begin
                cnt_d          = '0;
                shift_d[idx_q] = rx_s;
                idx_d          = idx_q + 1'b1;
                if (idx_q == 3'd7) state_d = ST_STOP;
            end
            // Leaving at mid-stop-bit gives half a bit of slack to catch a
            // start bit that follows immediately.
            ST_STOP: if (cnt_q == FULL_M1) begin
                cnt_d   = '0;
                valid_d = rx_s;
                ferr_d  = !rx_s;
                data_d  = rx_s ? shift_q : data_q;
                state_d = rx_s ? ST_IDLE : ST_BREAK;
            end
            // A line held low after a bad stop bit must not look like a new start bit.
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.rx_busy   = state_q != ST_IDLE;
endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: randomized and directed frames checked against a frame-level line-sampling model
module tb_uart_rx_8n1;
    localparam int C   = 16;
    localparam int H   = C / 2;
    localparam int LAT = 2 + H + 9 * C;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;

    uart_rx_8n1_if bus();

    uart_rx_8n1 #(.CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         good;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] model_data = 8'h00;
    int         valid_cycs[$];
    int         ferr_cnt = 0;
    int         busy_cnt = 0;
    int         run      = 0;
    int         last_gap = 0;
    bit         ev_v, ev_f;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Line level seen d cycles after the start edge for a sender with bit period p.
    function automatic logic line_at(int d, logic [7:0] b, int p, logic stop, logic after);
        int k;
        k = d / p;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9) return stop;
        return after;
    endfunction

    // The receiver samples the line at mid start bit, then every full bit period.
    function automatic void expect_frame(int t0, logic [7:0] b, int p, logic stop, logic after);
        ev_t        e;
        logic [7:0] got;
        if (line_at(H, b, p, stop, after)) return;
        for (int k = 1; k <= 8; k++) got[k-1] = line_at(H + k * C, b, p, stop, after);
        e.cyc  = t0 + LAT;
        e.good = line_at(H + 9 * C, b, p, stop, after);
        e.data = got;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            model_data = 8'h00;
            run        = 0;
            check("reset_data", bus.rx_data, 8'h00);
            check("reset_valid", bus.rx_valid, 1'b0);
            check("reset_ferr", bus.frame_err, 1'b0);
            check("reset_busy", bus.rx_busy, 1'b0);
        end else begin
            ev_v = 1'b0;
            ev_f = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                ev_v = exp_q[0].good;
                ev_f = !exp_q[0].good;
                if (ev_v) model_data = exp_q[0].data;
                void'(exp_q.pop_front());
            end
            check("rx_valid", bus.rx_valid, ev_v);
            check("frame_err", bus.frame_err, ev_f);
            check("rx_data", bus.rx_data, model_data);
            if (bus.rx_valid) valid_cycs.push_back(cyc);
            if (bus.frame_err) ferr_cnt++;
            if (bus.rx_busy) begin
                busy_cnt++;
                if (run > 0) last_gap = run;
                run = 0;
            end else run++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int p, input logic stop, input logic after, output int t0);
        t0 = cyc + 1;
        expect_frame(t0, b, p, stop, after);
        bus.uart_rx = 1'b0;
        tick(p);
        for (int k = 0; k < 8; k++) begin
            bus.uart_rx = b[k];
            tick(p);
        end
        bus.uart_rx = stop;
        tick(p);
    endtask

    initial begin
        int t0, t1;
        logic [7:0] rb;
        int rp;
        bus.uart_rx = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(5);

        // 1: single ideal frame, latency pinned by hand
        valid_cycs.delete();
        ferr_cnt = 0;
        send(8'h2A, C, 1'b1, 1'b1, t0);
        tick(10);
        check("t1_count", valid_cycs.size(), 1);
        if (valid_cycs.size() > 0) check("t1_latency", valid_cycs[0] - t0, 154);
        check("t1_data", bus.rx_data, 8'h2A);
        check("t1_no_ferr", ferr_cnt, 0);

        // 2: back-to-back frames with no idle gap
        valid_cycs.delete();
        send(8'h00, C, 1'b1, 1'b0, t0);
        send(8'hFF, C, 1'b1, 1'b1, t1);
        tick(10);
        check("t2_count", valid_cycs.size(), 2);
        if (valid_cycs.size() == 2) check("t2_spacing", valid_cycs[1] - valid_cycs[0], 160);
        check("t2_data", bus.rx_data, 8'hFF);
        check("t2_gap_le8", (last_gap >= 1 && last_gap <= 8), 1'b1);

        // 3: 4-cycle glitch on an idle line
        valid_cycs.delete();
        ferr_cnt = 0;
        busy_cnt = 0;
        bus.uart_rx = 1'b0;
        tick(4);
        bus.uart_rx = 1'b1;
        tick(30);
        check("t3_busy_len", (busy_cnt >= 1 && busy_cnt <= 10), 1'b1);
        check("t3_busy_low", bus.rx_busy, 1'b0);
        check("t3_no_valid", valid_cycs.size(), 0);
        check("t3_no_ferr", ferr_cnt, 0);
        check("t3_data", bus.rx_data, 8'hFF);

        // 4: bad stop bit, line held low, then recovery
        send(8'h55, C, 1'b0, 1'b0, t0);
        tick(40);
        check("t4_ferr", ferr_cnt, 1);
        check("t4_no_valid", valid_cycs.size(), 0);
        check("t4_data_kept", bus.rx_data, 8'hFF);
        check("t4_busy_break", bus.rx_busy, 1'b1);
        bus.uart_rx = 1'b1;
        tick(5);
        check("t4_busy_released", bus.rx_busy, 1'b0);
        send(8'hA5, C, 1'b1, 1'b1, t0);
        tick(10);
        check("t4_recover", bus.rx_data, 8'hA5);

        // 5: asynchronous reset during bit 3
        rb = 8'hF0;
        bus.uart_rx = 1'b0;
        tick(C);
        for (int k = 0; k < 3; k++) begin
            bus.uart_rx = rb[k];
            tick(C);
        end
        bus.uart_rx = rb[3];
        tick(H);
        check("t5_busy_before", bus.rx_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_async_data", bus.rx_data, 8'h00);
        check("t5_async_busy", bus.rx_busy, 1'b0);
        check("t5_async_valid", bus.rx_valid, 1'b0);
        check("t5_async_ferr", bus.frame_err, 1'b0);
        bus.uart_rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        valid_cycs.delete();
        ferr_cnt = 0;
        tick(20);
        check("t5_no_spurious", valid_cycs.size() + ferr_cnt, 0);
        send(8'h3C, C, 1'b1, 1'b1, t0);
        tick(10);
        check("t5_data", bus.rx_data, 8'h3C);

        // 6: sender bit period off by one cycle in both directions
        send(8'hC3, 15, 1'b1, 1'b1, t0);
        tick(20);
        check("t6_p15", bus.rx_data, 8'hC3);
        send(8'h00, C, 1'b1, 1'b1, t0);
        tick(10);
        send(8'hC3, 17, 1'b1, 1'b1, t0);
        tick(20);
        check("t6_p17", bus.rx_data, 8'hC3);

        // random bytes, bit periods and idle gaps
        for (int i = 0; i < 12; i++) begin
            rb = 8'($urandom);
            rp = int'($urandom_range(15, 17));
            send(rb, rp, 1'b1, 1'b1, t0);
            tick(int'($urandom_range(4, 20)));
        end
        tick(20);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
